// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, WIDTH steps per result.
// Define BIN_TO_BCD_SIGNED_EN to treat bin as two's complement (sign on negative, magnitude converted).
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            dbg_state_o
);

  // Handshake: start is accepted on a rising edge where the FSM is in IDLE or
  // DONE; busy is high for exactly the WIDTH SHIFT cycles; done is a single
  // cycle pulse in which bcd/negative first show the new result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      sh_q, sh_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  sign_q, sign_d;
  logic                  neg_q, neg_d;
  logic [4*DIGITS-1:0]   acc_step;
  logic [WIDTH-1:0]      mag;
  logic                  bin_sign;

`ifdef BIN_TO_BCD_SIGNED_EN
  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude.
  assign bin_sign = bin[WIDTH-1];
  assign mag      = bin_sign ? -bin : bin;
`else
  assign bin_sign = 1'b0;
  assign mag      = bin;
`endif

  // Digits above the top one only receive bits shifted up from below, so a
  // narrow accumulator naturally keeps the low DIGITS digits of the result.
  always_comb begin
    logic [4*DIGITS-1:0] adj;
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
    acc_step = {adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = CW'(WIDTH);
          sh_d    = mag;
          acc_d   = '0;
          sign_d  = bin_sign;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        acc_d = acc_step;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          bcd_d   = acc_step;
          neg_d   = sign_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
  end

  assign busy        = (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);
  assign bcd         = bcd_q;
  assign negative    = neg_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 16-bit/5-digit and an 8-bit/3-digit instance against
// an arithmetic decimal-digit model; follows BIN_TO_BCD_SIGNED_EN when defined.
module tb_bin_to_bcd_seq;

`ifdef BIN_TO_BCD_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0;
  logic [15:0] bin16   = '0;
  logic        busy16, done16, neg16;
  logic [19:0] bcd16;
  logic [1:0]  st16;

  logic        start8 = 1'b0;
  logic [7:0]  bin8   = '0;
  logic        busy8, done8, neg8;
  logic [11:0] bcd8;
  logic [1:0]  st8;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .negative(neg16), .bcd(bcd16),
    .dbg_state_o(st16)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .negative(neg8), .bcd(bcd8),
    .dbg_state_o(st8)
  );

  bit          sel8 = 1'b0;
  logic        done_s, busy_s, neg_s;
  logic [19:0] bcd_s;
  assign done_s = sel8 ? done8 : done16;
  assign busy_s = sel8 ? busy8 : busy16;
  assign neg_s  = sel8 ? neg8  : neg16;
  assign bcd_s  = sel8 ? {8'h00, bcd8} : bcd16;

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mag(input logic [31:0] v, input int w);
    logic [63:0] m;
    m = 64'(v) & ((64'd1 << w) - 64'd1);
    if (SIGNED_MODE && v[w-1]) m = (64'd1 << w) - m;
    return m;
  endfunction

  function automatic logic ref_neg(input logic [31:0] v, input int w);
    return SIGNED_MODE && v[w-1];
  endfunction

  function automatic logic [19:0] ref_bcd(input logic [31:0] v, input int w, input int d);
    logic [63:0] m, p;
    logic [19:0] r;
    m = ref_mag(v, w);
    p = 64'd1;
    r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'((m / p) % 64'd10);
      p = p * 64'd10;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; raises start, then counts edges until done.
  task automatic do_conv(input bit w8, input logic [31:0] v, input bit mid);
    int          lat, busy_n, hold_bad, w;
    bit          seen;
    logic [19:0] prev, exp_bcd;
    logic        exp_neg;
    sel8 = w8;
    w = w8 ? 8 : 16;
    exp_q.push_back(ref_bcd(v, w, w8 ? 3 : 5));
    exp_neg = ref_neg(v, w);
    #0 prev = bcd_s;
    if (w8) begin start8 = 1'b1; bin8 = v[7:0]; end
    else begin start16 = 1'b1; bin16 = v[15:0]; end
    lat = 0; busy_n = 0; hold_bad = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      start16 = 1'b0; start8 = 1'b0;
      lat++;
      if (mid && lat == 6) begin
        if (w8) begin start8 = 1'b1; bin8 = ~v[7:0]; end
        else begin start16 = 1'b1; bin16 = ~v[15:0]; end
      end
      @(negedge clk);
      if (done_s) seen = 1'b1;
      else begin
        if (busy_s) busy_n++;
        if (bcd_s !== prev) hold_bad++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", lat, w + 1);
    check("busy_cycles", busy_n, w);
    check("hold_until_done", hold_bad, 0);
    exp_bcd = exp_q.pop_front();
    check("bcd", 32'(bcd_s), 32'(exp_bcd));
    check("negative", 32'(neg_s), 32'(exp_neg));
    check("busy_in_done", 32'(busy_s), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_s), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d1, d2, nb, ndone, ndone_rst, bad_rst;
    logic [19:0] b1, b2;
    logic [31:0] v;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_done16", 32'(done16), 32'd0);
    check("rst_neg16",  32'(neg16),  32'd0);
    check("rst_bcd16",  32'(bcd16),  32'd0);
    check("rst_bcd8",   32'(bcd8),   32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // directed values
    do_conv(1'b0, 32'hFFFF, 1'b0);
`ifdef BIN_TO_BCD_SIGNED_EN
    check("s_ffff_bcd", 32'(bcd16), 32'h00001);
    check("s_ffff_neg", 32'(neg16), 32'd1);
    do_conv(1'b0, 32'h8000, 1'b0);
    check("s_8000_bcd", 32'(bcd16), 32'h32768);
    check("s_8000_neg", 32'(neg16), 32'd1);
`else
    check("u_ffff_bcd", 32'(bcd16), 32'h65535);
`endif
    do_conv(1'b0, 32'd0, 1'b0);
    do_conv(1'b0, 32'd9999, 1'b0);
    check("bcd_9999", 32'(bcd16), 32'h09999);
    do_conv(1'b0, 32'd777, 1'b1);

    // randomized values, every fourth one with a start pulse mid-conversion
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(0, 65535);
      do_conv(1'b0, v, (i % 4) == 0);
    end

    // start held high: 1234 then 4321, bin changed while in SHIFT
    sel8 = 1'b0;
    start16 = 1'b1; bin16 = 16'd1234;
    d1 = 0; d2 = 0; nb = 0; ndone = 0; b1 = '0; b2 = '0;
    for (int c = 1; c <= 60 && ndone < 2; c++) begin
      @(posedge clk); #1;
      if (c == 5) bin16 = 16'd4321;
      @(negedge clk);
      if (done16) begin
        ndone++;
        if (ndone == 1) begin d1 = c; b1 = bcd16; end
        else begin d2 = c; b2 = bcd16; start16 = 1'b0; end
      end else if (!busy16) nb++;
    end
    check("b2b_first_done", d1, 17);
    check("b2b_period", d2 - d1, 17);
    check("b2b_bcd1", 32'(b1), 32'(ref_bcd(32'd1234, 16, 5)));
    check("b2b_bcd2", 32'(b2), 32'(ref_bcd(32'd4321, 16, 5)));
    check("b2b_busy_gaps", nb, 0);
    @(posedge clk); #1;
    check("b2b_idle_busy", 32'(busy16), 32'd0);
    check("b2b_idle_done", 32'(done16), 32'd0);

    // reset in the middle of converting 5000
    start16 = 1'b1; bin16 = 16'd5000;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_bcd",  32'(bcd16),  32'd0);
    check("abort_busy", 32'(busy16), 32'd0);
    check("abort_done", 32'(done16), 32'd0);
    check("abort_neg",  32'(neg16),  32'd0);
    @(negedge clk); rst = 1'b0;
    ndone_rst = 0; bad_rst = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done16) ndone_rst++;
      if (bcd16 !== 20'h0) bad_rst++;
    end
    check("abort_no_done", ndone_rst, 0);
    check("abort_bcd_stays0", bad_rst, 0);
    @(posedge clk); #1;
    do_conv(1'b0, 32'd42, 1'b0);
    check("after_abort_42", 32'(bcd16), 32'h00042);

    // narrow instance
    do_conv(1'b1, 32'd255, 1'b0);
`ifndef BIN_TO_BCD_SIGNED_EN
    check("w8_255", 32'(bcd8), 32'h255);
`endif
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 255);
      do_conv(1'b1, v, i == 2);
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
